uart_rx_framer: RTL and testbench
=================================

# uart_rx_framer

UART receive framing controller that sits directly downstream of the bit sample counter. It synchronises the serial line, detects the start bit, and gates and clears the counter. It uses the counter's mid-bit shift pulse and end-of-bit strobe to assemble LSB-first data words, checks the stop bit, and presents each word on a valid/ready interface with framing-error and overrun flags.

## Interface
Parameters:
- DATA_BITS, default 8, data bits per frame (legal 5..9).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- rx  in  1  asynchronous serial line, idle high.
- shift  in  1  bit sample counter mid-bit pulse.
- strobe  in  1  bit sample counter end-of-bit pulse.
- cnt_en  out  1  enable to the bit sample counter.
- cnt_clr  out  1  synchronous clear to the bit sample counter.
- data  out  DATA_BITS  received word.
- valid  out  1  data holds an unread word.
- ready  in  1  consumer accepts data when valid and ready are both high.
- frame_err  out  1  stop bit sampled low for the word in data.
- overrun  out  1  one-cycle pulse when a completed word is dropped.

## Operation
- rx passes through a 2-FF synchroniser (rx_s); both stages reset to 1.
- shift and strobe are rising-edge detected (previous-value registers reset to 0). Each counter pulse therefore acts once, even if it is held high while cnt_en is low. Edges are ignored in IDLE.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on rx_s == 0, go to START.
  - START:
    - shift edge with rx_s == 1: false start; go to IDLE.
    - shift edge with rx_s == 0: stay in START.
    - strobe edge: go to DATA with bit_idx = 0.
  - DATA:
    - shift edge: shreg <= {rx_s, shreg[DATA_BITS-1:1]}, so the first bit ends up in the LSB.
    - strobe edge: if bit_idx == DATA_BITS-1, go to STOP; otherwise increment bit_idx.
  - STOP: on shift edge, complete the frame (below) and go to IDLE. The FSM does not wait for the strobe, so the next start edge can be caught half a bit early.
- bit_idx is $clog2(DATA_BITS) bits wide and is cleared on entry to DATA.
- Counter control: cnt_clr = (state == IDLE) and cnt_en = (state != IDLE). Both are decoded from the registered state, with no combinational path from rx.
- Frame completion in STOP, on the shift edge:
  - If valid == 0, or valid && ready in the same cycle: data <= shreg, valid <= 1, frame_err <= ~rx_s.
  - Otherwise: data and frame_err are unchanged, valid stays 1, and overrun pulses for one cycle.
- Handshake:
  - valid stays high until a valid && ready cycle, then clears on the next edge.
  - data and frame_err are stable while valid is high.
  - If accept and load happen in the same cycle, the load wins and valid stays 1.
- Reset values:
  - state IDLE, so cnt_clr = 1 and cnt_en = 0.
  - data = 0, valid = 0, frame_err = 0, overrun = 0.
  - shreg = 0, bit_idx = 0.
- Reset mid-frame abandons the frame and discards any unread word.

## Timing
- From a falling edge on rx to cnt_en high: 3 clk (2 synchroniser stages plus 1 state register).
- Shift and strobe actions occur 1 clk after the input pulse rises (edge-detect register).
- valid rises 1 clk after the stop-bit shift pulse.
- With 16 enabled counter cycles per bit, a frame completes about 9.5 bit times after the start edge.
- overrun is asserted in the same cycle that valid would otherwise have been reloaded.
- With ready tied high, valid is exactly one clk wide.
- No output has a combinational path from any input except through registers.

## Test plan
Each scenario uses the team's bit sample counter with a 16-clk-per-bit enable stream and DATA_BITS = 8.
1. Frame 0xA5 with a good stop bit and ready = 1 -> data = 0xA5, valid high for 1 clk, frame_err = 0, cnt_clr high again after the stop-bit shift pulse.
2. rx low for 4 counter samples, then high (glitch) -> return to IDLE at the first shift pulse, no valid, cnt_clr = 1, cnt_en = 0.
3. Frame 0x3C with the stop bit driven low -> valid with data = 0x3C and frame_err = 1.
4. ready = 0, frames 0x11 then 0x22 -> data holds 0x11, overrun pulses once at the second frame's stop sample; after ready rises, valid clears and data stays 0x11.
5. Back-to-back frames 0x00 and 0xFF with no idle gap and ready = 1 -> two valid pulses with 0x00 then 0xFF, frame_err = 0 on both.
6. rst asserted mid-DATA for 1 clk -> valid = 0, data = 0, cnt_clr = 1 the next cycle; a following frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_framer_if.sv
// uart_rx_framer_if: received-word valid/ready handshake with framing and overrun flags.
interface uart_rx_framer_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 frame_err;
    logic                 overrun;
    modport master (output data, valid, frame_err, overrun, input ready);
    modport slave (input data, valid, frame_err, overrun, output ready);
endinterface

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: UART receive framing around an external bit sample counter.
module uart_rx_framer #(
    parameter int DATA_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    input  logic              shift_i,
    input  logic              strobe_i,
    output logic              cnt_en_o,
    output logic              cnt_clr_o,
    uart_rx_framer_if.master  bus
);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;
    logic                 rx_s1_q, rx_s_q, shift_q, strobe_q;
    logic [1:0]           state_q, state_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic                 shift_e, strobe_e;
    assign shift_e  = shift_i & ~shift_q;
    assign strobe_e = strobe_i & ~strobe_q;
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        ferr_d    = ferr_q;
        ovr_d     = 1'b0;
        valid_d   = valid_q & ~bus.ready;
        case (state_q)
            IDLE:  state_d = rx_s_q ? IDLE : START;
            START: begin
                if (strobe_e) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end else if (shift_e && rx_s_q) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (shift_e) shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                if (strobe_e) begin
                    if (bit_idx_q == IW'(DATA_BITS - 1)) state_d = STOP;
                    else bit_idx_d = bit_idx_q + IW'(1);
                end
            end
            default: begin
                // Complete on the stop-bit sample so the next start edge is not missed.
                if (shift_e) begin
                    state_d = IDLE;
                    if (!valid_q || bus.ready) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        ferr_d  = ~rx_s_q;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            shift_q   <= 1'b0;
            strobe_q  <= 1'b0;
            state_q   <= IDLE;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_s1_q   <= rx_i;
            rx_s_q    <= rx_s1_q;
            shift_q   <= shift_i;
            strobe_q  <= strobe_i;
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end
    assign cnt_clr_o     = state_q == IDLE;
    assign cnt_en_o      = state_q != IDLE;
    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: scoreboard bench driving serial frames through a 16-clk-per-bit sample counter.
module tb_uart_rx_framer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic shift, strobe, cnt_en, cnt_clr;
    logic [3:0] cnt = 4'd0;
    int pass_cnt = 0;
    int total_cnt = 0;
    int ov_seen = 0;
    int ov_exp = 0;
    logic prev_acc = 1'b0;
    logic [8:0] exp_q[$];
    uart_rx_framer_if #(.DATA_BITS(8)) bus ();
    uart_rx_framer #(.DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .rx_i(rx), .shift_i(shift), .strobe_i(strobe),
        .cnt_en_o(cnt_en), .cnt_clr_o(cnt_clr), .bus(bus)
    );
    always #5 clk = ~clk;
    always_ff @(posedge clk) cnt <= cnt_clr ? 4'd0 : (cnt_en ? cnt + 4'd1 : cnt);
    assign shift  = cnt_en && cnt == 4'd7;
    assign strobe = cnt_en && cnt == 4'd15;
    // Monitor: pops one expected {data, frame_err} per accepted word.
    always @(negedge clk) begin
        if (rst) begin
            prev_acc = 1'b0;
        end else begin
            logic [8:0] e;
            if (bus.overrun) ov_seen++;
            if (prev_acc) begin
                total_cnt++;
                if (bus.valid) $display("FAIL valid_width: valid=%0b after accept, want 0", bus.valid);
                else pass_cnt++;
            end
            prev_acc = bus.valid && bus.ready;
            if (prev_acc) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected: data=%h ferr=%0b, want no word", bus.data, bus.frame_err);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.data, bus.frame_err} == e) pass_cnt++;
                    else $display("FAIL sb_word: data=%h ferr=%0b, want data=%h ferr=%0b",
                                  bus.data, bus.frame_err, e[8:1], e[0]);
                end
            end
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total_cnt++;
        if (act === want) pass_cnt++;
        else $display("FAIL %s: got %0h, want %0h", name, act, want);
    endtask
    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        clks(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            clks(16);
        end
        rx = stop;
        clks(16);
        rx = 1'b1;
    endtask
    initial begin
        bus.ready = 1'b1;
        clks(3);
        rst = 1'b0;
        chk("rst_cnt_clr", cnt_clr, 1);
        chk("rst_cnt_en", cnt_en, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_data", bus.data, 0);
        chk("rst_ferr", bus.frame_err, 0);
        chk("rst_overrun", bus.overrun, 0);
        clks(5);
        exp_q.push_back({8'hA5, 1'b0});
        send_frame(8'hA5, 1'b1);
        chk("s1_cnt_clr", cnt_clr, 1);
        clks(20);
        rx = 1'b0;
        clks(2);
        chk("s2_en_lat2", cnt_en, 0);
        clks(1);
        chk("s2_en_lat3", cnt_en, 1);
        clks(3);
        rx = 1'b1;
        clks(30);
        chk("s2_cnt_clr", cnt_clr, 1);
        chk("s2_cnt_en", cnt_en, 0);
        chk("s2_valid", bus.valid, 0);
        exp_q.push_back({8'h3C, 1'b1});
        send_frame(8'h3C, 1'b0);
        clks(40);
        bus.ready = 1'b0;
        exp_q.push_back({8'h11, 1'b0});
        send_frame(8'h11, 1'b1);
        ov_exp++;
        send_frame(8'h22, 1'b1);
        clks(10);
        chk("s4_valid_held", bus.valid, 1);
        chk("s4_data_held", bus.data, 8'h11);
        chk("s4_overrun_cnt", ov_seen, ov_exp);
        bus.ready = 1'b1;
        clks(2);
        chk("s4_valid_clr", bus.valid, 0);
        chk("s4_data_keep", bus.data, 8'h11);
        clks(10);
        exp_q.push_back({8'h00, 1'b0});
        exp_q.push_back({8'hFF, 1'b0});
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        clks(20);
        bus.ready = 1'b0;
        send_frame(8'h99, 1'b1);
        clks(5);
        chk("s6_pending", bus.valid, 1);
        rx = 1'b0;
        clks(16 + 48);
        rst = 1'b1;
        clks(1);
        rst = 1'b0;
        chk("s6_valid", bus.valid, 0);
        chk("s6_data", bus.data, 0);
        chk("s6_cnt_clr", cnt_clr, 1);
        rx = 1'b1;
        bus.ready = 1'b1;
        clks(30);
        exp_q.push_back({8'h5A, 1'b0});
        send_frame(8'h5A, 1'b1);
        clks(20);
        chk("end_queue_empty", exp_q.size(), 0);
        chk("end_overrun_cnt", ov_seen, ov_exp);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
